// File: rtl/list_pkg.sv
// Shared definitions for the list-fetch cache and the list packer:
// default widths, lane-count helper, and TKEEP mask construction.
package list_pkg;

    localparam int DW_DEFAULT  = 32;
    localparam int DBW_DEFAULT = 256;

    // Widest TKEEP the mask helper can build (8192-bit beats); callers
    // truncate the result to their own DBW/8.
    localparam int MAX_KEEP_W  = 1024;

    // Elements per beat.
    function automatic int fs(input int dw, input int dbw);
        return dbw / dw;
    endfunction

    // Lane index at the default geometry.
    typedef logic [$clog2(DBW_DEFAULT / DW_DEFAULT)-1:0] lane_t;

    // Byte enables for lanes 0..count-1; every other byte is zero.
    function automatic logic [MAX_KEEP_W-1:0] keep_mask(input int count,
                                                        input int dw = DW_DEFAULT);
        logic [MAX_KEEP_W-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_KEEP_W; b++) begin
            if (b < count * (dw / 8)) m[b] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/list_packer_if.sv
// Element input handshake plus AXI4-Stream output of the list packer.
// slave: the packer's view; master: the HoP source / stream sink view.
interface list_packer_if
    import list_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int DBW = DBW_DEFAULT
) ();

    logic [DW-1:0]    IN;
    logic             I_VALID;
    logic             I_LAST;
    logic             O_READY;
    logic [DBW-1:0]   TDATA;
    logic [DBW/8-1:0] TKEEP;
    logic             TLAST;
    logic             TVALID;
    logic             TREADY;

    modport slave (
        input  IN, I_VALID, I_LAST, TREADY,
        output O_READY, TDATA, TKEEP, TLAST, TVALID
    );

    modport master (
        output IN, I_VALID, I_LAST, TREADY,
        input  O_READY, TDATA, TKEEP, TLAST, TVALID
    );

endinterface

// File: rtl/list_packer_axis_out_reg.sv
// One-entry AXI4-Stream output register. A beat is loaded whenever the
// slot is empty or draining; a stalled beat is never altered or withdrawn.
module axis_out_reg #(
    parameter int DBW = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DBW-1:0]   data_i,
    input  logic [DBW/8-1:0] keep_i,
    input  logic             last_i,
    input  logic             tready_i,
    output logic             can_load_o,
    output logic             tvalid_o,
    output logic [DBW-1:0]   tdata_o,
    output logic [DBW/8-1:0] tkeep_o,
    output logic             tlast_o
);

    logic             valid_q;
    logic [DBW-1:0]   data_q;
    logic [DBW/8-1:0] keep_q;
    logic             last_q;

    // Slot accepts a new beat when empty or handing its beat over this cycle.
    assign can_load_o = ~valid_q | tready_i;

    // Beat register: load takes priority, otherwise a handshake empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            valid_q <= 1'b1;
            data_q  <= data_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
        end else if (tready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign tvalid_o = valid_q;
    assign tdata_o  = data_q;
    assign tkeep_o  = keep_q;
    assign tlast_o  = last_q;

endmodule

// File: rtl/list_packer.sv
// Packs DW-bit list elements into DBW-bit AXI4-Stream beats. An assembly
// register collects lanes; completed beats move to axis_out_reg, or wait in
// the assembly register (O_READY low) while the output is stalled.
module list_packer
    import list_pkg::*;
#(
    parameter int DW  = DW_DEFAULT,
    parameter int DBW = DBW_DEFAULT
) (
    input  logic         ACLK,
    input  logic         ARESETn,
    list_packer_if.slave bus
);

    localparam int FS = fs(DW, DBW);
    localparam int LW = (FS > 1) ? $clog2(FS) : 1;
    localparam int KW = DBW / 8;

    typedef logic [LW-1:0] lane_w_t;
    typedef logic [LW:0]   count_t;

    logic [DBW-1:0] asm_data_q, asm_data_d;
    lane_w_t        lane_q,     lane_d;
    count_t         asm_cnt_q,  asm_cnt_d;
    logic           asm_last_q, asm_last_d;
    logic           asm_full_q, asm_full_d;
    logic           ready_q,    ready_d;

    logic           accept;
    logic           complete;
    logic           can_load;
    logic           out_load;
    logic [DBW-1:0] beat_src;
    count_t         beat_cnt;
    logic           beat_last;
    logic [DBW-1:0] beat_data;
    logic [KW-1:0]  beat_keep;

    // Lane fill, beat completion, hand-off to the output register.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        asm_data_d = asm_data_q;
        lane_d     = lane_q;
        asm_cnt_d  = asm_cnt_q;
        asm_last_d = asm_last_q;
        asm_full_d = asm_full_q;
        beat_data  = '0;

        accept   = bus.I_VALID & ready_q;
        complete = accept & (bus.I_LAST | (lane_q == lane_w_t'(FS - 1)));

        if (accept) asm_data_d[int'(lane_q) * DW +: DW] = bus.IN;

        if (complete) begin
            lane_d     = '0;
            asm_cnt_d  = {1'b0, lane_q} + count_t'(1);
            asm_last_d = bus.I_LAST;
        end else if (accept) begin
            lane_d = lane_q + lane_w_t'(1);
        end

        // A held beat always goes first; O_READY is low while one is held,
        // so it can never coincide with a fresh completion.
        out_load = can_load & (asm_full_q | complete);

        if (asm_full_q & can_load)      asm_full_d = 1'b0;
        else if (complete & ~can_load)  asm_full_d = 1'b1;

        ready_d = ~asm_full_d;

        if (asm_full_q) begin
            beat_src  = asm_data_q;
            beat_cnt  = asm_cnt_q;
            beat_last = asm_last_q;
        end else begin
            beat_src  = asm_data_d;
            beat_cnt  = asm_cnt_d;
            beat_last = asm_last_d;
        end

        // Lanes beyond the fill count still hold stale elements; blank them.
        for (int k = 0; k < FS; k++) begin
            if (count_t'(k) < beat_cnt) beat_data[k * DW +: DW] = beat_src[k * DW +: DW];
        end

        beat_keep = KW'(keep_mask(int'(beat_cnt), DW));
    end

    // Assembly state; O_READY is registered and comes up one edge after reset.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            // NOTE: the assembly buffer is cleared too, so no stale lanes survive reset.
            asm_data_q <= '0;
            lane_q     <= '0;
            asm_cnt_q  <= '0;
            asm_last_q <= 1'b0;
            asm_full_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            asm_data_q <= asm_data_d;
            lane_q     <= lane_d;
            asm_cnt_q  <= asm_cnt_d;
            asm_last_q <= asm_last_d;
            asm_full_q <= asm_full_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.O_READY = ready_q;

    axis_out_reg #(.DBW(DBW)) u_out (
        .clk        (ACLK),
        .rst_n      (ARESETn),
        .load_i     (out_load),
        .data_i     (beat_data),
        .keep_i     (beat_keep),
        .last_i     (beat_last),
        .tready_i   (bus.TREADY),
        .can_load_o (can_load),
        .tvalid_o   (bus.TVALID),
        .tdata_o    (bus.TDATA),
        .tkeep_o    (bus.TKEEP),
        .tlast_o    (bus.TLAST)
    );

endmodule

// File: tb/tb_list_packer.sv
// Bench for list_packer at DW=32, DBW=256. A negedge monitor keeps a
// list-level model (elements grouped into beats of up to 8, closed early by
// I_LAST) and scores every output handshake and every stalled cycle.
module tb_list_packer;

    localparam int DW  = 32;
    localparam int DBW = 256;
    localparam int FS  = 8;
    localparam int KW  = 32;

    typedef struct {
        logic [DBW-1:0] data;
        logic [KW-1:0]  keep;
        logic           last;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    list_packer_if #(.DW(DW), .DBW(DBW)) bus ();

    list_packer #(.DW(DW), .DBW(DBW)) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int compared    = 0;
    int mismatched  = 0;
    int tready_mode = 0;   // 0: always ready, 1: stalled, 2: random
    int acc_cnt     = 0;
    int beat_cnt    = 0;

    logic [DW-1:0] cur_q[$];
    beat_t         exp_q[$];
    beat_t         log_q[$];

    // Downstream TREADY, changed mid-cycle so the next edge sees a settled value.
    initial begin
        bus.TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (tready_mode)
                0:       bus.TREADY = 1'b1;
                1:       bus.TREADY = 1'b0;
                default: bus.TREADY = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    // Reference model and scoreboard, sampled at the falling edge.
    initial begin
        beat_t got;
        beat_t exp;
        beat_t held;
        logic  hold_prev;
        hold_prev = 1'b0;
        held      = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_q.delete();
                exp_q.delete();
                hold_prev = 1'b0;
            end else begin
                got.data = bus.TDATA;
                got.keep = bus.TKEEP;
                got.last = bus.TLAST;
                if (hold_prev) begin
                    compared++;
                    if (bus.TVALID !== 1'b1 || got.data !== held.data ||
                        got.keep !== held.keep || got.last !== held.last) begin
                        mismatched++;
                        $display("FAIL axi_stable: valid=%0b keep=%h last=%0b data=%h, required valid=1 keep=%h last=%0b data=%h",
                                 bus.TVALID, got.keep, got.last, got.data, held.keep, held.last, held.data);
                    end
                end
                if (bus.TVALID === 1'b1 && bus.TREADY === 1'b1) begin
                    log_q.push_back(got);
                    beat_cnt++;
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_beat: data=%h keep=%h last=%0b, required no beat",
                                 got.data, got.keep, got.last);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got.data !== exp.data || got.keep !== exp.keep || got.last !== exp.last) begin
                            mismatched++;
                            $display("FAIL beat: data=%h keep=%h last=%0b, required data=%h keep=%h last=%0b",
                                     got.data, got.keep, got.last, exp.data, exp.keep, exp.last);
                        end
                    end
                end
                hold_prev = (bus.TVALID === 1'b1) && (bus.TREADY !== 1'b1);
                held      = got;
                if (bus.I_VALID === 1'b1 && bus.O_READY === 1'b1) begin
                    cur_q.push_back(bus.IN);
                    acc_cnt++;
                    if (cur_q.size() == FS || bus.I_LAST === 1'b1) begin
                        exp.data = '0;
                        exp.keep = '0;
                        exp.last = bus.I_LAST;
                        for (int i = 0; i < cur_q.size(); i++) exp.data[i*DW +: DW] = cur_q[i];
                        for (int b = 0; b < cur_q.size() * (DW / 8); b++) exp.keep[b] = 1'b1;
                        exp_q.push_back(exp);
                        cur_q.delete();
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Offer one element and hold it until the handshake edge has passed.
    task automatic send(input logic [DW-1:0] d, input logic last, output int waits);
        bus.IN      = d;
        bus.I_VALID = 1'b1;
        bus.I_LAST  = last;
        waits       = 0;
        forever begin
            @(negedge clk);
            if (bus.O_READY === 1'b1) begin
                @(posedge clk);
                #1;
                break;
            end
            waits++;
            if (waits > 2000) begin
                compared++;
                mismatched++;
                $display("FAIL send_timeout: O_READY low for %0d cycles, required handshake", waits);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.I_VALID = 1'b0;
        bus.I_LAST  = 1'b0;
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    // Bounded wait for the model's pending beats to appear at the output.
    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d beats pending after %0d cycles, required 0", exp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        bus.IN = '0; bus.I_VALID = 1'b0; bus.I_LAST = 1'b0;
        #2;
        compared += 5;
        if (bus.O_READY !== 1'b0) begin mismatched++; $display("FAIL reset_o_ready: %b, required 0", bus.O_READY); end
        if (bus.TVALID  !== 1'b0) begin mismatched++; $display("FAIL reset_tvalid: %b, required 0", bus.TVALID); end
        if (bus.TLAST   !== 1'b0) begin mismatched++; $display("FAIL reset_tlast: %b, required 0", bus.TLAST); end
        if (bus.TKEEP   !== '0)   begin mismatched++; $display("FAIL reset_tkeep: %h, required 0", bus.TKEEP); end
        if (bus.TDATA   !== '0)   begin mismatched++; $display("FAIL reset_tdata: %h, required 0", bus.TDATA); end
        #10;
        rst_n = 1'b1;
        #1;
        compared++;
        if (bus.O_READY !== 1'b0) begin mismatched++; $display("FAIL ready_before_edge: %b, required 0", bus.O_READY); end
        @(negedge clk);
        compared++;
        if (bus.O_READY !== 1'b1) begin mismatched++; $display("FAIL ready_after_edge: %b, required 1", bus.O_READY); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_two_full_beats();
        int w, tot;
        logic [DBW-1:0] e;
        tot = 0;
        log_q.delete();
        for (int i = 1; i <= 16; i++) begin
            send(DW'(i), (i == 16), w);
            tot += w;
        end
        idle(0);
        wait_drain(100);
        compared += 2;
        if (tot !== 0) begin mismatched++; $display("FAIL full_ready_high: %0d stall cycles, required 0", tot); end
        if (log_q.size() !== 2) begin
            mismatched++;
            $display("FAIL full_beat_count: %0d, required 2", log_q.size());
        end else begin
            for (int b = 0; b < 2; b++) begin
                e = '0;
                for (int k = 0; k < FS; k++) e[k*DW +: DW] = DW'(b * FS + k + 1);
                compared += 3;
                if (log_q[b].data !== e) begin mismatched++; $display("FAIL full_data%0d: %h, required %h", b, log_q[b].data, e); end
                if (log_q[b].keep !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL full_keep%0d: %h, required ffffffff", b, log_q[b].keep); end
                if (log_q[b].last !== (b == 1)) begin mismatched++; $display("FAIL full_last%0d: %b, required %b", b, log_q[b].last, (b == 1)); end
            end
        end
    endtask

    task automatic test_short_list();
        int w;
        logic [DBW-1:0] e;
        e = '0;
        e[31:0] = 32'hA; e[63:32] = 32'hB; e[95:64] = 32'hC;
        send(32'hA, 1'b0, w);
        send(32'hB, 1'b0, w);
        compared++;
        if (bus.TVALID !== 1'b0) begin mismatched++; $display("FAIL short_early_valid: %b, required 0", bus.TVALID); end
        send(32'hC, 1'b1, w);
        idle(0);
        @(negedge clk);
        compared += 4;
        if (bus.TVALID !== 1'b1) begin mismatched++; $display("FAIL short_latency: TVALID=%b, required 1", bus.TVALID); end
        if (bus.TKEEP !== 32'h0000_0FFF) begin mismatched++; $display("FAIL short_keep: %h, required 00000fff", bus.TKEEP); end
        if (bus.TLAST !== 1'b1) begin mismatched++; $display("FAIL short_last: %b, required 1", bus.TLAST); end
        if (bus.TDATA !== e) begin mismatched++; $display("FAIL short_data: %h, required %h", bus.TDATA, e); end
        wait_drain(50);
    endtask

    task automatic test_backpressure();
        int w, a0, b0;
        a0 = acc_cnt;
        b0 = beat_cnt;
        tready_mode = 1;
        fork
            begin
                for (int i = 0; i < 24; i++) send(DW'(100 + i), (i == 23), w);
                idle(0);
            end
            begin
                repeat (40) @(posedge clk);
                #1;
                compared += 4;
                if (acc_cnt - a0 !== 16) begin mismatched++; $display("FAIL bp_accepts: %0d, required 16", acc_cnt - a0); end
                if (bus.O_READY !== 1'b0) begin mismatched++; $display("FAIL bp_ready_low: %b, required 0", bus.O_READY); end
                if (bus.TVALID !== 1'b1) begin mismatched++; $display("FAIL bp_tvalid: %b, required 1", bus.TVALID); end
                if (bus.TDATA[31:0] !== 32'd100) begin mismatched++; $display("FAIL bp_first_lane: %0d, required 100", bus.TDATA[31:0]); end
                tready_mode = 0;
            end
        join
        wait_drain(200);
        compared += 2;
        if (acc_cnt - a0 !== 24) begin mismatched++; $display("FAIL bp_total_accepts: %0d, required 24", acc_cnt - a0); end
        if (beat_cnt - b0 !== 3) begin mismatched++; $display("FAIL bp_beats: %0d, required 3", beat_cnt - b0); end
    endtask

    task automatic test_back_to_back();
        int w;
        log_q.delete();
        for (int i = 0; i < 5; i++) send(DW'(300 + i), (i == 4), w);
        for (int i = 0; i < 3; i++) send(DW'(400 + i), (i == 2), w);
        idle(0);
        wait_drain(100);
        compared++;
        if (log_q.size() !== 2) begin
            mismatched++;
            $display("FAIL b2b_beat_count: %0d, required 2", log_q.size());
        end else begin
            compared += 4;
            if (log_q[0].keep !== 32'h000F_FFFF) begin mismatched++; $display("FAIL b2b_keep0: %h, required 000fffff", log_q[0].keep); end
            if (log_q[1].keep !== 32'h0000_0FFF) begin mismatched++; $display("FAIL b2b_keep1: %h, required 00000fff", log_q[1].keep); end
            if (log_q[0].last !== 1'b1) begin mismatched++; $display("FAIL b2b_last0: %b, required 1", log_q[0].last); end
            if (log_q[1].last !== 1'b1) begin mismatched++; $display("FAIL b2b_last1: %b, required 1", log_q[1].last); end
        end
    endtask

    task automatic test_reset_mid();
        int w, b0;
        logic [DBW-1:0] e;
        tready_mode = 1;
        for (int i = 0; i < 8; i++) send(DW'(500 + i), (i == 7), w);
        for (int i = 0; i < 4; i++) send(DW'(600 + i), 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        compared += 2;
        if (bus.TVALID !== 1'b0) begin mismatched++; $display("FAIL mid_reset_tvalid: %b, required 0", bus.TVALID); end
        if (bus.O_READY !== 1'b0) begin mismatched++; $display("FAIL mid_reset_ready: %b, required 0", bus.O_READY); end
        bus.I_VALID = 1'b0;
        bus.I_LAST  = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tready_mode = 0;
        @(posedge clk);
        #1;
        b0 = beat_cnt;
        log_q.delete();
        e = '0;
        for (int i = 0; i < 8; i++) begin
            send(DW'(700 + i), (i == 7), w);
            e[i*DW +: DW] = DW'(700 + i);
        end
        idle(10);
        wait_drain(50);
        compared++;
        if (beat_cnt - b0 !== 1) begin
            mismatched++;
            $display("FAIL post_reset_beats: %0d, required 1", beat_cnt - b0);
        end else begin
            compared += 3;
            if (log_q[0].data !== e) begin mismatched++; $display("FAIL post_reset_data: %h, required %h", log_q[0].data, e); end
            if (log_q[0].keep !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL post_reset_keep: %h, required ffffffff", log_q[0].keep); end
            if (log_q[0].last !== 1'b1) begin mismatched++; $display("FAIL post_reset_last: %b, required 1", log_q[0].last); end
        end
    endtask

    task automatic test_random();
        int w, a0, n, len;
        a0 = acc_cnt;
        n  = 0;
        tready_mode = 2;
        while (n < 10000) begin
            len = $urandom_range(1, 20);
            for (int j = 0; j < len && n < 10000; j++) begin
                send($urandom, (j == len - 1) || (n == 9999), w);
                n++;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        idle(0);
        tready_mode = 0;
        wait_drain(5000);
        compared += 2;
        if (acc_cnt - a0 !== n) begin mismatched++; $display("FAIL rand_accepts: %0d, required %0d", acc_cnt - a0, n); end
        if (cur_q.size() !== 0) begin mismatched++; $display("FAIL rand_leftover: %0d elements, required 0", cur_q.size()); end
    endtask

    initial begin
        test_reset();
        test_two_full_beats();
        test_short_list();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
